serial_parity_unit: RTL and testbench

Parametrised serial parity engine for single-bit serial links: accumulates parity over fixed-length frames of FRAME_LEN data bits. In generate mode it emits the parity bit for each frame; in check mode it consumes the trailing received parity bit and flags mismatches. It sits between a bit-serial receiver/transmitter and the frame logic, and keeps a saturating count of bad frames.

---
 rtl/serial_parity_pkg.sv | 31 +++
 rtl/serial_parity_unit_accum.sv | 33 +++
 rtl/serial_parity_unit.sv | 171 +++++++++++++++++
 tb/tb_serial_parity_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_pkg.sv
// -----------------------------------------------------------------------------
// serial_parity_pkg
//
// Shared definitions for the serial parity engine:
//   state_t    - frame FSM states (IDLE / DATA / PAR)
//   EVEN, ODD  - values of odd_mode
//   GEN, CHK   - values of check_mode
//   cnt_width  - width of the per-frame bit counter for a given frame length
// -----------------------------------------------------------------------------
package serial_parity_pkg;

  // IDLE : no bits accepted in the current frame
  // DATA : 1..FRAME_LEN-1 data bits accepted
  // PAR  : check mode, all data bits in, waiting for the received parity bit
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;
  localparam logic GEN  = 1'b0;
  localparam logic CHK  = 1'b1;

  // The counter has to represent FRAME_LEN itself (held while in PAR).
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/serial_parity_unit_accum.sv
// -----------------------------------------------------------------------------
// parity_accum
//
// One-bit XOR accumulator holding the running parity of the current frame.
//
// Ports:
//   clock   in  rising-edge clock
//   reset_n in  asynchronous active-low reset, forces z to 0
//   clear   in  synchronous clear, priority over en
//   en      in  fold d into the accumulator this cycle
//   d       in  bit to fold in
//   z       out registered running XOR
// -----------------------------------------------------------------------------
module parity_accum (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  input  logic d,
  output logic z
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      z <= 1'b0;
    end else if (clear) begin
      z <= 1'b0;
    end else if (en) begin
      z <= z ^ d;
    end
  end

endmodule

// File: rtl/serial_parity_unit.sv
// -----------------------------------------------------------------------------
// serial_parity_unit
//
// Bit-serial parity engine for fixed-length frames of FRAME_LEN data bits.
// Generate mode emits the parity bit of each frame; check mode consumes the
// trailing received parity bit and flags a mismatch, keeping a saturating
// count of bad frames.
//
// Parameters:
//   FRAME_LEN  data bits per frame (>= 1)
//   ERR_CNT_W  width of the saturating bad-frame counter (>= 1)
//
// Ports:
//   clock       in  sole clock, rising edge
//   reset_n     in  asynchronous active-low reset
//   clear       in  synchronous frame abort, wins over in_valid
//   in_valid    in  x carries a bit this cycle
//   x           in  serial data bit (parity bit while in PAR)
//   odd_mode    in  0 even / 1 odd parity, taken on the first bit of a frame
//   check_mode  in  0 generate / 1 check, taken on the first bit of a frame
//   z           out running XOR of data bits accepted in this frame
//   bit_cnt     out data bits accepted in this frame
//   frame_done  out one-cycle pulse after the completing bit
//   parity_out  out parity bit of the last completed generate frame
//   parity_err  out mismatch flag of the last completed check frame
//   err_count   out saturating count of frames with parity_err = 1
// -----------------------------------------------------------------------------
module serial_parity_unit
  import serial_parity_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                clear,
  input  logic                                in_valid,
  input  logic                                x,
  input  logic                                odd_mode,
  input  logic                                check_mode,
  output logic                                z,
  output logic [cnt_width(FRAME_LEN)-1:0]     bit_cnt,
  output logic                                frame_done,
  output logic                                parity_out,
  output logic                                parity_err,
  output logic [ERR_CNT_W-1:0]                err_count
);

  localparam int                   CNT_W    = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_ONE;
  endfunction

  state_t state_p0;
  logic   odd_lat_p0;
  logic   chk_lat_p0;

  logic accept;
  logic in_par;
  logic odd_eff;
  logic chk_eff;
  logic last_data;
  logic gen_done;
  logic chk_done;
  logic done_now;
  logic data_par;
  logic acc_en;
  logic acc_clr;

  // ---- decode of the current bit ----
  // In IDLE the mode inputs are used live, so the first bit of a frame
  // (which may also be the last when FRAME_LEN = 1) already sees the mode
  // that gets latched on it.
  always_comb begin
    accept    = in_valid & ~clear;
    in_par    = (state_p0 == PAR);
    odd_eff   = (state_p0 == IDLE) ? odd_mode   : odd_lat_p0;
    chk_eff   = (state_p0 == IDLE) ? check_mode : chk_lat_p0;
    last_data = accept & ~in_par & (bit_cnt == LAST_IDX);
    gen_done  = last_data & (chk_eff == GEN);
    chk_done  = accept & in_par;
    done_now  = gen_done | chk_done;
    // z excludes the bit on x, so this is the XOR including the current bit
    // (the data bit in DATA, the received parity bit in PAR).
    data_par  = z ^ x;
    acc_en    = accept & ~in_par;
    // Completion returns z to 0 on the same edge, overriding the fold-in.
    acc_clr   = clear | done_now;
  end

  parity_accum u_accum (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (acc_clr),
    .en      (acc_en),
    .d       (x),
    .z       (z)
  );

  // ---- frame FSM, bit counter and mode latches ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_p0   <= IDLE;
      bit_cnt    <= '0;
      odd_lat_p0 <= EVEN;
      chk_lat_p0 <= GEN;
    end else if (clear) begin
      state_p0 <= IDLE;
      bit_cnt  <= '0;
    end else if (accept) begin
      if (state_p0 == IDLE) begin
        odd_lat_p0 <= odd_mode;
        chk_lat_p0 <= check_mode;
      end
      case (state_p0)
        IDLE, DATA: begin
          if (last_data) begin
            if (chk_eff == CHK) begin
              state_p0 <= PAR;
              bit_cnt  <= bit_cnt + CNT_ONE;
            end else begin
              state_p0 <= IDLE;
              bit_cnt  <= '0;
            end
          end else begin
            state_p0 <= DATA;
            bit_cnt  <= bit_cnt + CNT_ONE;
          end
        end
        PAR: begin
          state_p0 <= IDLE;
          bit_cnt  <= '0;
        end
        default: begin
          state_p0 <= IDLE;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // ---- result registers ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
      parity_out <= 1'b0;
      parity_err <= 1'b0;
      err_count  <= '0;
    end else begin
      frame_done <= done_now;
      if (clear) begin
        parity_out <= 1'b0;
        parity_err <= 1'b0;
      end else if (gen_done) begin
        parity_out <= data_par ^ odd_eff;
        parity_err <= 1'b0;
      end else if (chk_done) begin
        parity_err <= (data_par != odd_eff);
        if (data_par != odd_eff) begin
          err_count <= sat_inc(err_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_unit.sv
module tb_serial_parity_unit;

  localparam int FL = 8;
  localparam int EW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          in_valid;
  logic          x;
  logic          odd_mode;
  logic          check_mode;
  logic          z;
  logic [3:0]    bit_cnt;
  logic          frame_done;
  logic          parity_out;
  logic          parity_err;
  logic [EW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  serial_parity_unit #(.FRAME_LEN(FL), .ERR_CNT_W(EW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .x          (x),
    .odd_mode   (odd_mode),
    .check_mode (check_mode),
    .z          (z),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done),
    .parity_out (parity_out),
    .parity_err (parity_err),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic v, input logic b, input logic c);
    in_valid = v;
    x        = b;
    clear    = c;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  // Eight data bits, first bit = d[7]. Mode inputs are inverted after the
  // first bit; the DUT must ignore that.
  task automatic send_data(input logic [7:0] d, input logic om, input logic cm);
    for (int i = 7; i >= 0; i--) begin
      odd_mode   = (i == 7) ? om : ~om;
      check_mode = (i == 7) ? cm : ~cm;
      step(1'b1, d[i], 1'b0);
      if (i > 0) begin
        chk("bit_cnt_mid", 32'(bit_cnt), 32'(8 - i));
        chk("no_done_mid", 32'(frame_done), 0);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    x          = 1'b0;
    odd_mode   = 1'b0;
    check_mode = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("rst_bit_cnt", 32'(bit_cnt), 0);
    chk("rst_done", 32'(frame_done), 0);

    // Asynchronous reset mid-frame after 3 bits
    odd_mode = 1'b0; check_mode = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("pre_rst_cnt", 32'(bit_cnt), 3);
    chk("pre_rst_z", 32'(z), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_z", 32'(z), 0);
    chk("async_cnt", 32'(bit_cnt), 0);
    chk("async_done", 32'(frame_done), 0);
    chk("async_pout", 32'(parity_out), 0);
    chk("async_perr", 32'(parity_err), 0);
    chk("async_ecnt", 32'(err_count), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Generate, even: 1,0,1,1,0,0,1,0 -> four ones -> parity 0
    send_data(8'b10110010, 1'b0, 1'b0);
    chk("gen_even_done", 32'(frame_done), 1);
    chk("gen_even_pout", 32'(parity_out), 0);
    chk("gen_even_perr", 32'(parity_err), 0);
    chk("gen_even_cnt0", 32'(bit_cnt), 0);
    chk("gen_even_z0", 32'(z), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("gen_even_pulse", 32'(frame_done), 0);

    // Generate, odd: same stream -> parity 1, held afterwards
    send_data(8'b10110010, 1'b1, 1'b0);
    chk("gen_odd_done", 32'(frame_done), 1);
    chk("gen_odd_pout", 32'(parity_out), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("gen_odd_pulse", 32'(frame_done), 0);
    chk("gen_odd_hold", 32'(parity_out), 1);

    // Check, odd: 1,1,0,0,0,0,0,1 (three ones) + parity 0 -> good
    send_data(8'b11000001, 1'b1, 1'b1);
    chk("chk_par_cnt", 32'(bit_cnt), 8);
    chk("chk_par_nodone", 32'(frame_done), 0);
    chk("chk_par_z", 32'(z), 1);
    odd_mode = 1'b0; check_mode = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chk("chk_ok_done", 32'(frame_done), 1);
    chk("chk_ok_perr", 32'(parity_err), 0);
    chk("chk_ok_ecnt", 32'(err_count), 0);
    chk("chk_ok_cnt0", 32'(bit_cnt), 0);
    step(1'b0, 1'b0, 1'b0);

    // Same data + parity 1 -> mismatch
    send_data(8'b11000001, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("chk_bad_done", 32'(frame_done), 1);
    chk("chk_bad_perr", 32'(parity_err), 1);
    chk("chk_bad_ecnt", 32'(err_count), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("chk_bad_hold", 32'(parity_err), 1);

    // Gap of 3 idle cycles between bits 4 and 5: 1,1,1,0 | 0,0,0,0 even -> 1
    odd_mode = 1'b0; check_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b1, 1'b0);
          chk("gap_cnt", 32'(bit_cnt), 4);
          chk("gap_z", 32'(z), 1);
        end
      end
      step(1'b1, (i < 3) ? 1'b1 : 1'b0, 1'b0);
    end
    chk("gap_done", 32'(frame_done), 1);
    chk("gap_pout", 32'(parity_out), 1);
    chk("gap_perr", 32'(parity_err), 0);
    // Back-to-back: next frame starts in the frame_done cycle, odd, one 1 -> 0
    send_data(8'b01000000, 1'b1, 1'b0);
    chk("b2b_done", 32'(frame_done), 1);
    chk("b2b_pout", 32'(parity_out), 0);
    chk("b2b_cnt0", 32'(bit_cnt), 0);
    step(1'b0, 1'b0, 1'b0);

    // clear after 5 bits (1,0,1,0,1) with in_valid high on the clear cycle
    odd_mode = 1'b0; check_mode = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("clr_pre_cnt", 32'(bit_cnt), 5);
    chk("clr_pre_z", 32'(z), 1);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_cnt", 32'(bit_cnt), 0);
    chk("clr_z", 32'(z), 0);
    chk("clr_nodone", 32'(frame_done), 0);
    chk("clr_perr", 32'(parity_err), 0);
    chk("clr_ecnt_kept", 32'(err_count), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("clr_nodone2", 32'(frame_done), 0);
    // Full frame after clear: seven ones, even -> parity 1
    send_data(8'b11111110, 1'b0, 1'b0);
    chk("post_clr_done", 32'(frame_done), 1);
    chk("post_clr_pout", 32'(parity_out), 1);
    step(1'b0, 1'b0, 1'b0);

    // Saturation with a 2-bit counter: five bad even check frames
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    chk("sat_start", 32'(err_count), 0);
    for (int k = 0; k < 5; k++) begin
      send_data(8'h00, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      chk("sat_perr", 32'(parity_err), 1);
      chk("sat_ecnt", 32'(err_count), (k + 1 > 3) ? 3 : k + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
